// File: rtl/fruit_spawner.sv
// Spawn scheduler: periodically requests a value from the rng over new/num,
// turns each accepted sample into a (lane, speed) event and queues it for the game core.
module fruit_spawner #(
    parameter int PERIOD    = 50_000_000,
    parameter int HOLD      = 4,
    parameter int SETTLE    = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                     ck,
    input  logic                     reset,
    input  logic                     on,
    input  logic [4:0]               num_i,
    output logic                     new_o,
    output logic                     spawn_valid,
    input  logic                     spawn_ready,
    output logic [2:0]               spawn_lane,
    output logic [1:0]               spawn_speed,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNTW   = AW + 1;
    localparam int CW_MAX = (PERIOD > HOLD) ? ((PERIOD > SETTLE) ? PERIOD : SETTLE)
                                            : ((HOLD > SETTLE) ? HOLD : SETTLE);
    localparam int CW     = $clog2(CW_MAX + 1);
    localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ_HI,
        S_REQ_LO,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [RW-1:0]   retries;
    logic [2:0]      last_lane;
    logic            last_valid;
    logic            push, retry, do_push, pop, full;
    logic [4:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      head;

    // Sequencer: one shared cycle counter, cleared on every state change
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (!on) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        push      = 1'b0;
        retry     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (on) state_nxt = S_WAIT;
            end
            S_WAIT:   if (cnt == CW'(PERIOD - 1)) state_nxt = S_REQ_HI;
            S_REQ_HI: if (cnt == CW'(HOLD - 1))   state_nxt = S_REQ_LO;
            S_REQ_LO: if (cnt == CW'(HOLD - 1))   state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == CW'(SETTLE - 1)) state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                // A repeat of the previous lane is re-rolled a bounded number of times
                if (last_valid && (num_i[2:0] == last_lane) && (retries < RW'(MAX_RETRY))) begin
                    retry     = 1'b1;
                    state_nxt = S_REQ_HI;
                end else begin
                    push      = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Request line and lane history; new_o comes straight from a flop
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            new_o      <= 1'b0;
            retries    <= '0;
            last_lane  <= '0;
            last_valid <= 1'b0;
        end else if (!on) begin
            new_o      <= 1'b0;
            retries    <= '0;
            last_lane  <= '0;
            last_valid <= 1'b0;
        end else begin
            new_o <= (state_nxt == S_REQ_HI);
            if (retry) retries <= retries + RW'(1);
            if (push) begin
                retries    <= '0;
                last_lane  <= num_i[2:0];
                last_valid <= 1'b1;
            end
        end
    end

    // Spawn FIFO, first-word-fall-through
    assign full        = (fifo_count == CNTW'(DEPTH));
    assign spawn_valid = (fifo_count != '0);
    assign pop         = spawn_valid && spawn_ready;
    assign do_push     = push && (!full || pop);
    assign head        = mem[rd_ptr];
    assign spawn_lane  = spawn_valid ? head[2:0] : 3'd0;
    assign spawn_speed = spawn_valid ? head[4:3] : 2'd0;

    always_ff @(posedge ck) begin
        if (do_push) mem[wr_ptr] <= num_i;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (!on) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fruit_spawner.sv
// Bench for fruit_spawner: an event-schedule model (request times, capture times,
// queue of entries) is checked every cycle, plus directed literal checks.
module tb_fruit_spawner;

    localparam int PERIOD    = 10;
    localparam int HOLD      = 2;
    localparam int SETTLE    = 2;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       on = 1'b0;
    logic [4:0] num_i = 5'd0;
    logic       spawn_ready = 1'b0;
    logic       new_o, spawn_valid, overflow;
    logic [2:0] spawn_lane;
    logic [1:0] spawn_speed;
    logic [2:0] fifo_count;

    int nvec = 0;
    int nerr = 0;

    fruit_spawner #(
        .PERIOD(PERIOD), .HOLD(HOLD), .SETTLE(SETTLE), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .ck(ck), .reset(reset), .on(on), .num_i(num_i), .new_o(new_o),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
        .spawn_speed(spawn_speed), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: schedule of request edges, queue of spawned entries
    int         m_e = 0;
    bit         m_active = 0;
    int         m_next_req = 0;
    bit         m_last_valid = 0;
    logic [2:0] m_last_lane = 3'd0;
    int         m_retries = 0;
    bit         m_ovf = 0;
    bit         m_new = 0;
    bit         m_popped;
    logic [4:0] q[$];

    task automatic model_step();
        m_e++;
        if (reset || !on) begin
            m_active = 0; q.delete(); m_ovf = 0; m_last_valid = 0;
            m_retries = 0; m_new = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_next_req = m_e + PERIOD;
            m_new = 0;
        end else begin
            m_popped = (q.size() != 0) && spawn_ready;
            if (m_popped) void'(q.pop_front());
            if (m_e == m_next_req + 2*HOLD + SETTLE + 1) begin
                if (m_last_valid && num_i[2:0] == m_last_lane && m_retries < MAX_RETRY) begin
                    m_retries++;
                    m_next_req = m_e;
                end else begin
                    if (q.size() < DEPTH) q.push_back(num_i);
                    else m_ovf = 1;
                    m_last_lane = num_i[2:0];
                    m_last_valid = 1;
                    m_retries = 0;
                    m_next_req = m_e + PERIOD;
                end
            end
            m_new = (m_e >= m_next_req) && (m_e < m_next_req + HOLD);
        end
    endtask

    initial forever begin
        @(posedge ck);
        model_step();
    end

    logic [4:0] m_head;
    initial forever begin
        @(negedge ck);
        m_head = (q.size() != 0) ? q[0] : 5'd0;
        chk("new_o", 32'(new_o), 32'(m_new));
        chk("spawn_valid", 32'(spawn_valid), 32'(q.size() != 0));
        chk("spawn_lane", 32'(spawn_lane), 32'(m_head[2:0]));
        chk("spawn_speed", 32'(spawn_speed), 32'(m_head[4:3]));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic tick();
        @(negedge ck);
        #1;
    endtask

    task automatic wait_for_new(output int k);
        k = 0;
        while (new_o !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("new_rise_seen", 32'(new_o), 32'd1);
    endtask

    task automatic wait_count(input int target);
        int k;
        k = 0;
        while (32'(fifo_count) != target && k < 60) begin
            tick();
            k++;
        end
        chk("count_reached", 32'(fifo_count), 32'(target));
    endtask

    initial begin
        int  k, spawns, rises;
        logic prev_new;

        // Reset: every output low
        repeat (3) tick();
        chk("rst_new", 32'(new_o), 32'd0);
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_lane", 32'(spawn_lane), 32'd0);
        chk("rst_speed", 32'(spawn_speed), 32'd0);

        // First request timing and pulse width
        reset = 1'b0; on = 1'b1; num_i = 5'b11010; spawn_ready = 1'b0;
        wait_for_new(k);
        chk("rise_delay", 32'(k), 32'd11);
        tick();
        chk("pulse_2nd", 32'(new_o), 32'd1);
        tick();
        chk("pulse_end", 32'(new_o), 32'd0);

        // First spawn 7 cycles after new_o rose
        repeat (4) tick();
        chk("pre_push_valid", 32'(spawn_valid), 32'd0);
        tick();
        chk("push_valid", 32'(spawn_valid), 32'd1);
        chk("push_lane", 32'(spawn_lane), 32'd2);
        chk("push_speed", 32'(spawn_speed), 32'd3);
        chk("push_count", 32'(fifo_count), 32'd1);

        // Same lane forever: second spawn needs four request pulses
        num_i = 5'd5; spawn_ready = 1'b1;
        spawns = 0; rises = 0; prev_new = new_o; k = 0;
        while (spawns < 2 && k < 120) begin
            tick();
            k++;
            if (new_o && !prev_new && spawns == 1) rises++;
            prev_new = new_o;
            if (spawn_valid && spawn_lane == 3'd5) spawns++;
        end
        chk("lane5_spawns", 32'(spawns), 32'd2);
        chk("retry_pulses", 32'(rises), 32'd4);
        tick();
        spawn_ready = 1'b0;

        // Fill past full: fifth spawn is dropped
        num_i = 5'd1; wait_count(1);
        num_i = 5'd2; wait_count(2);
        num_i = 5'd3; wait_count(3);
        num_i = 5'd4; wait_count(4);
        num_i = 5'd5;
        k = 0;
        while (overflow !== 1'b1 && k < 60) begin tick(); k++; end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("drain_0", 32'(spawn_lane), 32'd1);
        spawn_ready = 1'b1;
        tick(); chk("drain_1", 32'(spawn_lane), 32'd2);
        tick(); chk("drain_2", 32'(spawn_lane), 32'd3);
        tick(); chk("drain_3", 32'(spawn_lane), 32'd4);
        tick(); chk("drain_empty", 32'(spawn_valid), 32'd0);
        spawn_ready = 1'b0;

        // Disable in the second request-high cycle with two entries queued
        num_i = 5'd6; wait_count(1);
        num_i = 5'd7; wait_count(2);
        wait_for_new(k);
        tick();
        on = 1'b0;
        tick();
        chk("off_new", 32'(new_o), 32'd0);
        chk("off_count", 32'(fifo_count), 32'd0);
        chk("off_valid", 32'(spawn_valid), 32'd0);
        chk("off_ovf", 32'(overflow), 32'd0);
        on = 1'b1;
        wait_for_new(k);
        chk("restart_delay", 32'(k), 32'd11);

        // Push and pop together while full
        num_i = 5'd8;  wait_count(1);
        num_i = 5'd9;  wait_count(2);
        num_i = 5'd10; wait_count(3);
        num_i = 5'd12; wait_count(4);
        num_i = 5'b01011;
        wait_for_new(k);
        repeat (6) tick();
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(spawn_lane), 32'd1);
        spawn_ready = 1'b1;
        tick(); chk("pp_d1", 32'(spawn_lane), 32'd2);
        tick(); chk("pp_d2", 32'(spawn_lane), 32'd4);
        tick(); chk("pp_tail_lane", 32'(spawn_lane), 32'd3);
        chk("pp_tail_speed", 32'(spawn_speed), 32'd1);

        // Randomised traffic: repeated lanes, back-pressure, enable drops, one reset
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = (i >= 1500 && i < 1502);
            on = ($urandom_range(0, 299) != 0);
            spawn_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 1)
                num_i = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 1))};
            else
                num_i = 5'($urandom);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
